// File: rtl/wave_nco.sv
// wave_nco -- numerically controlled oscillator with a valid/ready sample output.
//
// A phase accumulator advances by freq_i on every accepted sample and the
// registered output is a waveform derived from the new phase: saw, triangle,
// square or silence.
//
// Parameters:
//   width_p        sample width (signed two's complement)
//   phase_width_p  phase accumulator width, must be >= width_p+1
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   reset_ni  synchronous active-low reset
//   freq_i    phase increment per accepted sample
//   mode_i    00 saw, 01 triangle, 10 square, 11 silence
//   enable_i  phase advances on a handshake only when high
//   sync_i    restart phase at 0 (held pending until the next handshake)
//   ready_i   downstream accepts data_o
//   duty_i    (only with WAVE_NCO_DUTY_EN) square high while phase[top 8] < duty_i
//   valid_o   data_o holds a valid sample
//   data_o    current signed sample
//
// Build option: define WAVE_NCO_DUTY_EN to add duty_i and a variable-duty square.

module wave_nco #(
  parameter int unsigned width_p       = 12,
  parameter int unsigned phase_width_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [phase_width_p-1:0] freq_i,
  input  logic [1:0]               mode_i,
  input  logic                     enable_i,
  input  logic                     sync_i,
  input  logic                     ready_i,
`ifdef WAVE_NCO_DUTY_EN
  input  logic [7:0]               duty_i,
`endif
  output logic                     valid_o,
  output logic [width_p-1:0]       data_o
);

  logic [phase_width_p-1:0] phase_q;
  logic                     sync_pend_q;
  logic                     valid_q;
  logic [width_p-1:0]       data_q;

  logic                     load;
  logic [phase_width_p-1:0] phase_next;
  logic                     m;
  logic [width_p-1:0]       q;
  logic [width_p-1:0]       saw;
  logic [width_p-1:0]       tri_fold;
  logic [width_p-1:0]       tri_wave;
  logic [width_p-1:0]       sq_pos;
  logic [width_p-1:0]       sq_neg;
  logic                     sq_high;
  logic [width_p-1:0]       sample;

  // A new sample is loaded on every handshake, and unconditionally on the
  // first edge after reset (valid_q still low) so the stream starts itself.
  assign load = !valid_q || ready_i;

  always_comb begin
    phase_next = phase_q;
    if (!valid_q || sync_i || sync_pend_q) begin
      phase_next = '0;
    end else if (enable_i) begin
      phase_next = phase_q + freq_i;
    end
  end

  assign m = phase_next[phase_width_p-1];
  assign q = phase_next[phase_width_p-2 -: width_p];

  assign saw      = {~m, q[width_p-1:1]};
  assign tri_fold = m ? ~q : q;
  assign tri_wave = {~tri_fold[width_p-1], tri_fold[width_p-2:0]};

  assign sq_pos = {1'b0, {(width_p-1){1'b1}}};
  assign sq_neg = '0 - sq_pos;

`ifdef WAVE_NCO_DUTY_EN
  assign sq_high = phase_next[phase_width_p-1 -: 8] < duty_i;
`else
  assign sq_high = !m;
`endif

  always_comb begin
    sample = '0;
    case (mode_i)
      2'b00:   sample = saw;
      2'b01:   sample = tri_wave;
      2'b10:   sample = sq_high ? sq_pos : sq_neg;
      default: sample = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      phase_q     <= '0;
      sync_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else if (load) begin
      phase_q     <= phase_next;
      sync_pend_q <= 1'b0;
      valid_q     <= 1'b1;
      data_q      <= sample;
    end else if (sync_i) begin
      sync_pend_q <= 1'b1;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_wave_nco.sv
// Self-checking bench for wave_nco (width_p=12, phase_width_p=16).
// A sample-level model tracks the phase of the sample on the output and
// derives the waveform value arithmetically; directed literal sequences pin
// the model to hand-computed values.

module tb_wave_nco;

  localparam int unsigned W  = 12;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] freq = '0;
  logic [1:0]    mode = 2'b00;
  logic          en = 1'b1;
  logic          sync = 1'b0;
  logic          ready = 1'b1;
`ifdef WAVE_NCO_DUTY_EN
  logic [7:0]    duty = 8'h40;
`endif
  logic          valid;
  logic [W-1:0]  data;

  int checks = 0;
  int errors = 0;

  // model state
  int m_phase = 0;
  int m_valid = 0;
  int m_pend  = 0;
  int m_data  = 0;

  wave_nco #(.width_p(W), .phase_width_p(PW)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .freq_i  (freq),
    .mode_i  (mode),
    .enable_i(en),
    .sync_i  (sync),
    .ready_i (ready),
`ifdef WAVE_NCO_DUTY_EN
    .duty_i  (duty),
`endif
    .valid_o (valid),
    .data_o  (data)
  );

  always #5 clk = ~clk;

  // Waveform value as a function of a 16-bit phase, from the arithmetic shape
  // of each waveform rather than from bit slicing.
  function automatic int wave(int p, logic [1:0] md);
    case (md)
      2'b00: return (p / 16) - 2048;
      2'b01: return (p < 32768) ? (p / 8) - 2048 : 2047 - ((p - 32768) / 8);
`ifdef WAVE_NCO_DUTY_EN
      2'b10: return ((p / 256) < int'(duty)) ? 2047 : -2047;
`else
      2'b10: return (p < 32768) ? 2047 : -2047;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      m_valid = 0; m_phase = 0; m_pend = 0; m_data = 0;
    end else if (m_valid == 0) begin
      m_valid = 1; m_phase = 0; m_data = wave(0, mode);
    end else if (ready) begin
      if (sync || m_pend != 0) m_phase = 0;
      else if (en) m_phase = (m_phase + int'(freq)) % 65536;
      m_pend = 0;
      m_data = wave(m_phase, mode);
    end else if (sync) begin
      m_pend = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_valid", int'(valid), m_valid);
    chk("model_data", int'($signed(data)), m_data);
  endtask

  task automatic lit(input string name, input int exp);
    chk(name, int'($signed(data)), exp);
  endtask

  int tri_seq[8] = '{-1024, 0, 1024, 2047, 1023, -1, -1025, -2048};
`ifdef WAVE_NCO_DUTY_EN
  int sq_seq[8] = '{2047, -2047, -2047, -2047, -2047, -2047, -2047, 2047};
`else
  int sq_seq[8] = '{2047, 2047, 2047, -2047, -2047, -2047, -2047, 2047};
`endif

  initial begin
    // reset state
    tick(); tick();
    chk("reset_valid", int'(valid), 0);
    lit("reset_data", 0);

    // saw, freq 0x1000: 17 samples incl. wrap
    rst_n = 1'b1; mode = 2'b00; freq = 16'h1000; ready = 1'b1; en = 1'b1;
    tick();
    chk("release_valid", int'(valid), 1);
    lit("saw_0", -2048);
    for (int i = 1; i <= 16; i++) begin
      tick();
      lit($sformatf("saw_%0d", i), -2048 + 256 * (i % 16));
    end
    tick();
    lit("saw_17", -1792);

    // stall: held regardless of input changes
    ready = 1'b0; freq = 16'h7777; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", int'(valid), 1);
      lit("stall_data", -1792);
    end
    freq = 16'h1000; en = 1'b1; ready = 1'b1;
    tick(); lit("resume_0", -1536);
    tick(); lit("resume_1", -1280);

    // sync while stalled
    ready = 1'b0; sync = 1'b1;
    tick(); lit("sync_hold_0", -1280);
    sync = 1'b0;
    tick(); lit("sync_hold_1", -1280);
    ready = 1'b1;
    tick(); lit("sync_load", -2048);
    tick(); lit("sync_next", -1792);

    // handshake with enable low: phase kept, mode change takes effect
    en = 1'b0;
    tick(); lit("en0_hold", -1792);
    mode = 2'b10;
    tick(); lit("en0_mode", 2047);
    en = 1'b1;

    // triangle from phase 0
    mode = 2'b01; freq = 16'h2000; sync = 1'b1;
    tick(); lit("tri_0", -2048);
    sync = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lit($sformatf("tri_%0d", i + 1), tri_seq[i]);
    end

    // square from phase 0
    mode = 2'b10; sync = 1'b1;
    tick(); lit("sq_0", 2047);
    sync = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lit($sformatf("sq_%0d", i + 1), sq_seq[i]);
    end

    // silence
    mode = 2'b11;
    tick(); lit("silence", 0);
    tick();

    // freq 0: constant saw
    mode = 2'b00; freq = 16'h0000; sync = 1'b1;
    tick(); sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("freq0", -2048);
    end

    // negative increment wraps downward
    freq = 16'hFFFF;
    tick(); lit("wrap_down", 2047);
    for (int i = 0; i < 4; i++) tick();
    freq = 16'h0FFF; mode = 2'b01;
    for (int i = 0; i < 6; i++) tick();

    // mid-stream reset with a pending sync and a stalled sample
    ready = 1'b0; sync = 1'b1; mode = 2'b00; freq = 16'h1000;
    tick(); sync = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", int'(valid), 0);
    lit("midrst_data", 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_rel_valid", int'(valid), 1);
    lit("midrst_rel_data", -2048);
    ready = 1'b1;
    tick(); lit("midrst_next", -1792);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_nco.md
WAVE_NCO -- requirements
Module: wave_nco

Interface
REQ-001 SHALL have parameter width_p, default 12, meaning sample width in bits (signed two's complement output).
REQ-002 SHALL have parameter phase_width_p, default 24, meaning phase accumulator width; legal values are phase_width_p >= width_p+1.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port freq_i  input  phase_width_p  meaning the phase increment per accepted sample (Fout = freq_i * Fsample / 2^phase_width_p).
REQ-006 SHALL have port mode_i  input  2  meaning waveform select: 00 saw, 01 triangle, 10 square, 11 silence.
REQ-007 SHALL have port enable_i  input  1  meaning that the phase advances on handshake only when high.
REQ-008 SHALL have port sync_i  input  1  meaning a request to restart the phase at 0.
REQ-009 SHALL have port ready_i  input  1  meaning the downstream consumer accepts data_o.
REQ-010 SHALL have port valid_o  output  1  meaning data_o holds a valid sample.
REQ-011 SHALL have port data_o  output  width_p  meaning the current signed sample.

Function
REQ-012 SHALL keep phase_q (phase_width_p bits) equal to the phase of the sample currently on data_o; the handshake is valid_o && ready_i.
REQ-013 SHALL, on handshake with enable_i=1, set phase_q to (phase_q+freq_i) mod 2^phase_width_p and register data_o = f(new phase, mode_i) in the same edge, so valid_o stays high with no bubble.
REQ-014 SHALL, on handshake with enable_i=0, keep phase_q and recompute data_o = f(phase_q, mode_i), so that a mode change still takes effect.
REQ-015 SHALL, without a handshake, hold data_o, valid_o and phase_q unchanged regardless of freq_i, mode_i or enable_i changes.
REQ-016 SHALL define m = phase MSB and q = the width_p phase bits immediately below m.
REQ-017 SHALL map saw as data = {~m, q[width_p-1:1]} interpreted as signed (phase 0 -> -2^(width_p-1)).
REQ-018 SHALL map triangle as data = (m ? ~q : q) with its MSB inverted, so it rises over the first half-cycle and falls over the second.
REQ-019 SHALL map square as +(2^(width_p-1)-1) when m=0 and -(2^(width_p-1)-1) when m=1; silence (11) SHALL map to 0.
REQ-020 SHALL, when sync_i=1 at a handshake edge, set phase_q=0 and data_o=f(0, mode_i), taking priority over enable_i.
REQ-021 SHALL, when sync_i=1 without a handshake, set an internal sync_pend flag and hold data_o; the next handshake SHALL load phase 0 and clear the flag.
REQ-022 SHALL produce a constant output when freq_i=0, and SHALL wrap phase modulo 2^phase_width_p with no saturation.

Reset
REQ-023 SHALL, while reset_ni=0 at a clock edge, set phase_q=0, sync_pend=0, valid_o=0 and data_o=0.
REQ-024 SHALL, on the first edge with reset_ni=1 after reset, set valid_o=1 and data_o=f(0, mode_i), independent of ready_i.
REQ-025 SHALL, when reset is asserted mid-stream, abandon any held sample and any pending sync.

Configuration
REQ-026 SHALL, when macro WAVE_NCO_DUTY_EN is defined, add port duty_i (input, 8 bits); square SHALL then be high when phase[top 8 bits] < duty_i and low otherwise (duty_i=0 gives always low, 0x80 gives 50%).
REQ-027 SHALL, when WAVE_NCO_DUTY_EN is undefined, omit duty_i and use the fixed 50% square of REQ-019.

Verification (width_p=12, phase_width_p=16)
REQ-028 SHALL cover reset release with saw, freq_i=0x1000, ready_i=1 -> data_o sequence -2048, -1792, -1536, ..., 1792, then -2048 on the 17th sample (wrap).
REQ-029 SHALL cover triangle, freq_i=0x2000 -> data_o sequence -2048, -1024, 0, 1024, 2047, 1023, -1, -1025, -2048.
REQ-030 SHALL cover ready_i=0 for 5 cycles mid-stream -> valid_o=1 and data_o and phase held; after ready_i returns, the sequence resumes with no skipped samples.
REQ-031 SHALL cover sync_i pulsed while ready_i=0 -> data_o held; the next handshake yields f(0) (saw -2048) and the sequence continues from phase 0.
REQ-032 SHALL cover square mode without the macro -> 2047 for phase < 0x8000 and -2047 otherwise; with WAVE_NCO_DUTY_EN and duty_i=0x40 -> high for 25% of samples.
REQ-033 SHALL cover reset_ni=0 for one cycle mid-stream -> next edge valid_o=0 and data_o=0, the following edge valid_o=1 and data_o=f(0).
